// File: rtl/video_pattern_gen_if.sv
// Video output bus from the pattern generator to the scanline/effects chain.
interface video_pattern_gen_if;
    logic [23:0] dout;
    logic        hs_out;
    logic        vs_out;
    logic        de_out;
    logic [11:0] x;
    logic [11:0] y;
    logic        frame_start;

    modport master (
        output dout, hs_out, vs_out, de_out, x, y, frame_start
    );

    modport slave (
        input dout, hs_out, vs_out, de_out, x, y, frame_start
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Raster timing generator with per-frame selectable RGB888 test patterns.
module video_pattern_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned BAR_W    = 80
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce_pix,
    input  logic [1:0]                 pattern,
    input  logic [23:0]                color,
    video_pattern_gen_if.master        vid
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region thresholds carry one extra bit so a 4096 boundary still fits.
    localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
    localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
    localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

    logic [11:0] hcnt;
    logic [11:0] vcnt;
    logic [11:0] bar_cnt;
    logic [2:0]  bar_idx;
    logic [1:0]  pat_q;
    logic [23:0] col_q;

    logic [12:0] h13;
    logic [12:0] v13;
    logic        h_act_c;
    logic        v_act_c;
    logic        h_sync_c;
    logic        v_sync_c;
    logic        de_c;
    logic        first_px_c;
    logic        h_wrap_c;
    logic        grid_c;
    logic [1:0]  pat_eff_c;
    logic [23:0] col_eff_c;
    logic [23:0] bar_rgb_c;
    logic [23:0] pix_c;

    assign h13 = {1'b0, hcnt};
    assign v13 = {1'b0, vcnt};

    // Decode regions and pick the pixel colour for the current counter state.
    always_comb begin
        h_act_c    = h13 < H_ACT_END;
        v_act_c    = v13 < V_ACT_END;
        h_sync_c   = (h13 >= H_SYNC_BEG) && (h13 < H_SYNC_END);
        v_sync_c   = (v13 >= V_SYNC_BEG) && (v13 < V_SYNC_END);
        de_c       = h_act_c && v_act_c;
        first_px_c = (hcnt == 12'd0) && (vcnt == 12'd0);
        h_wrap_c   = hcnt == H_LAST;
        // Pixel (0,0) already uses the pattern being latched on that edge.
        pat_eff_c  = first_px_c ? pattern : pat_q;
        col_eff_c  = first_px_c ? color   : col_q;

        case (bar_idx)
            3'd0:    bar_rgb_c = 24'hFFFFFF;
            3'd1:    bar_rgb_c = 24'hFFFF00;
            3'd2:    bar_rgb_c = 24'h00FFFF;
            3'd3:    bar_rgb_c = 24'h00FF00;
            3'd4:    bar_rgb_c = 24'hFF00FF;
            3'd5:    bar_rgb_c = 24'hFF0000;
            3'd6:    bar_rgb_c = 24'h0000FF;
            default: bar_rgb_c = 24'h000000;
        endcase

        grid_c = (hcnt[3:0] == 4'd0) || (vcnt[3:0] == 4'd0) ||
                 (hcnt == X_LAST) || (vcnt == Y_LAST);

        case (pat_eff_c)
            2'd0:    pix_c = bar_rgb_c;
            2'd1:    pix_c = grid_c ? 24'hFFFFFF : 24'h000000;
            2'd2:    pix_c = {hcnt[7:0], vcnt[7:0], hcnt[7:0] ^ vcnt[7:0]};
            default: pix_c = col_eff_c;
        endcase
    end

    // Raster counters, per-frame pattern latch and the colour-bar stepper.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt    <= '0;
            vcnt    <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            pat_q   <= '0;
            col_q   <= '0;
        end else if (ce_pix) begin
            if (h_wrap_c) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
            end else begin
                hcnt <= hcnt + 12'd1;
            end

            if (first_px_c) begin
                pat_q <= pattern;
                col_q <= color;
            end

            if (h_wrap_c) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (h_act_c) begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    if (bar_idx != 3'd7) begin
                        bar_idx <= bar_idx + 3'd1;
                    end
                end else begin
                    bar_cnt <= bar_cnt + 12'd1;
                end
            end
        end
    end

    // Registered video outputs, one ce cycle behind the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid.dout        <= '0;
            vid.hs_out      <= 1'b0;
            vid.vs_out      <= 1'b0;
            vid.de_out      <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.frame_start <= 1'b0;
        end else if (ce_pix) begin
            vid.dout        <= de_c ? pix_c : 24'h000000;
            vid.hs_out      <= h_sync_c;
            vid.vs_out      <= v_sync_c;
            vid.de_out      <= de_c;
            vid.frame_start <= first_px_c;
            if (de_c) begin
                vid.x <= hcnt;
                vid.y <= vcnt;
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a 16x8 raster with single-pixel colour bars.
module tb_video_pattern_gen;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int BW = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_pix;
    logic [1:0]  pattern;
    logic [23:0] color;

    video_pattern_gen_if vif ();

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .BAR_W(BW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ce_pix  (ce_pix),
        .pattern (pattern),
        .color   (color),
        .vid     (vif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: raster position as a single pixel index.
    int          m_pos;
    logic [1:0]  m_pat;
    logic [23:0] m_col;
    logic [23:0] e_dout;
    logic        e_hs, e_vs, e_de, e_fs;
    logic [11:0] e_x, e_y;

    typedef struct {
        logic [23:0] dout;
        logic        hs, vs, de, fs;
        logic [11:0] x, y;
    } out_t;
    out_t rec [256];

    typedef struct {
        int          pos;
        logic [23:0] dout;
        logic        hs, vs, de, fs;
        logic [11:0] x, y;
    } vec_t;
    vec_t vt [29];

    logic [23:0] bar_lit [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_pixel(input logic [1:0] p, input int h, input int v,
                                              input logic [23:0] c);
        logic [7:0] hx, vy;
        int bi;
        hx = 8'(h);
        vy = 8'(v);
        bi = h / BW;
        if (bi > 7) bi = 7;
        case (p)
            2'd0: return bar_lit[bi];
            2'd1: return ((h % 16 == 0) || (v % 16 == 0) || (h == HA - 1) || (v == VA - 1))
                         ? 24'hFFFFFF : 24'h000000;
            2'd2: return {hx, vy, hx ^ vy};
            default: return c;
        endcase
    endfunction

    task automatic model_step();
        int h, v;
        if (reset) begin
            m_pos = 0; m_pat = 2'd0; m_col = 24'h0;
            e_dout = 24'h0; e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_x = 0; e_y = 0;
        end else if (ce_pix) begin
            h = m_pos % HT;
            v = m_pos / HT;
            if (m_pos == 0) begin
                m_pat = pattern;
                m_col = color;
            end
            e_de = (h < HA) && (v < VA);
            e_hs = (h >= HA + HFP) && (h < HA + HFP + HS);
            e_vs = (v >= VA + VFP) && (v < VA + VFP + VS);
            e_fs = (m_pos == 0);
            if (e_de) begin
                e_x = 12'(h);
                e_y = 12'(v);
                e_dout = ref_pixel(m_pat, h, v, m_col);
            end else begin
                e_dout = 24'h0;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("m_dout", 32'(vif.dout), 32'(e_dout));
        chk("m_hs", 32'(vif.hs_out), 32'(e_hs));
        chk("m_vs", 32'(vif.vs_out), 32'(e_vs));
        chk("m_de", 32'(vif.de_out), 32'(e_de));
        chk("m_fs", 32'(vif.frame_start), 32'(e_fs));
        chk("m_x", 32'(vif.x), 32'(e_x));
        chk("m_y", 32'(vif.y), 32'(e_y));
    endtask

    task automatic record(input int c);
        rec[c] = '{vif.dout, vif.hs_out, vif.vs_out, vif.de_out, vif.frame_start, vif.x, vif.y};
    endtask

    task automatic chk_rec(input int i, input int r);
        chk($sformatf("tv%0d_dout", vt[i].pos), 32'(rec[r].dout), 32'(vt[i].dout));
        chk($sformatf("tv%0d_hs", vt[i].pos), 32'(rec[r].hs), 32'(vt[i].hs));
        chk($sformatf("tv%0d_vs", vt[i].pos), 32'(rec[r].vs), 32'(vt[i].vs));
        chk($sformatf("tv%0d_de", vt[i].pos), 32'(rec[r].de), 32'(vt[i].de));
        chk($sformatf("tv%0d_fs", vt[i].pos), 32'(rec[r].fs), 32'(vt[i].fs));
        chk($sformatf("tv%0d_x", vt[i].pos), 32'(rec[r].x), 32'(vt[i].x));
        chk($sformatf("tv%0d_y", vt[i].pos), 32'(rec[r].y), 32'(vt[i].y));
    endtask

    task automatic check_table(input int stretch);
        for (int i = 0; i < 29; i++) begin
            for (int k = 0; k < stretch; k++) begin
                if (vt[i].pos * stretch + k < 256) chk_rec(i, vt[i].pos * stretch + k);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int de_n, vs_n, vs_first, vs_last;

        bar_lit[0] = 24'hFFFFFF; bar_lit[1] = 24'hFFFF00;
        bar_lit[2] = 24'h00FFFF; bar_lit[3] = 24'h00FF00;
        bar_lit[4] = 24'hFF00FF; bar_lit[5] = 24'hFF0000;
        bar_lit[6] = 24'h0000FF; bar_lit[7] = 24'h000000;

        // First line of colour bars, then selected boundary pixels.
        for (int i = 0; i < 16; i++) begin
            vt[i] = '{i, (i < 8) ? bar_lit[i] : 24'h0, (i >= 10 && i <= 12), 1'b0,
                      (i < 8), (i == 0), 12'((i < 8) ? i : 7), 12'd0};
        end
        vt[16] = '{16,  24'hFFFFFF, 0, 0, 1, 0, 12'd0, 12'd1};
        vt[17] = '{19,  24'h00FF00, 0, 0, 1, 0, 12'd3, 12'd1};
        vt[18] = '{26,  24'h000000, 1, 0, 0, 0, 12'd7, 12'd1};
        vt[19] = '{63,  24'h000000, 0, 0, 0, 0, 12'd7, 12'd3};
        vt[20] = '{64,  24'h000000, 0, 0, 0, 0, 12'd7, 12'd3};
        vt[21] = '{79,  24'h000000, 0, 0, 0, 0, 12'd7, 12'd3};
        vt[22] = '{80,  24'h000000, 0, 1, 0, 0, 12'd7, 12'd3};
        vt[23] = '{90,  24'h000000, 1, 1, 0, 0, 12'd7, 12'd3};
        vt[24] = '{111, 24'h000000, 0, 1, 0, 0, 12'd7, 12'd3};
        vt[25] = '{112, 24'h000000, 0, 0, 0, 0, 12'd7, 12'd3};
        vt[26] = '{127, 24'h000000, 0, 0, 0, 0, 12'd7, 12'd3};
        vt[27] = '{128, 24'hFFFFFF, 0, 0, 1, 1, 12'd0, 12'd0};
        vt[28] = '{133, 24'hFF0000, 0, 0, 1, 0, 12'd5, 12'd0};

        reset = 1'b1; ce_pix = 1'b1; pattern = 2'd0; color = 24'h0;
        m_pos = 0; m_pat = 0; m_col = 0;
        e_dout = 0; e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_x = 0; e_y = 0;

        // Reset state.
        repeat (3) tick();
        chk("rst_dout", 32'(vif.dout), 32'h0);
        chk("rst_de", 32'(vif.de_out), 32'h0);
        chk("rst_fs", 32'(vif.frame_start), 32'h0);

        // Colour bars, two full frames.
        reset = 1'b0;
        for (int c = 0; c < 256; c++) begin
            tick();
            record(c);
        end
        check_table(1);
        de_n = 0; vs_n = 0; vs_first = -1; vs_last = -1;
        for (int c = 0; c < FRAME; c++) begin
            if (rec[c].de) de_n++;
            if (rec[c].vs) begin
                vs_n++;
                if (vs_first < 0) vs_first = c;
                vs_last = c;
            end
        end
        chk("de_count", 32'(de_n), 32'd32);
        chk("vs_count", 32'(vs_n), 32'd32);
        chk("vs_first", 32'(vs_first), 32'd80);
        chk("vs_span", 32'(vs_last - vs_first + 1), 32'd32);

        // Same raster with ce_pix toggling: every output stretched x2.
        do_reset();
        for (int c = 0; c < 256; c++) begin
            ce_pix = (c % 2 == 0);
            tick();
            record(c);
        end
        ce_pix = 1'b1;
        check_table(2);

        // Solid pattern switched mid-frame; gradient only from the next frame.
        pattern = 2'd3; color = 24'h123456;
        do_reset();
        for (int c = 0; c < 192; c++) begin
            if (c == 32) pattern = 2'd2;
            if (c == 40) color = 24'h654321;
            tick();
            if (c == 32) chk("solid_0_2", 32'(vif.dout), 32'h123456);
            if (c == 35) chk("solid_3_2", 32'(vif.dout), 32'h123456);
            if (c == 49) chk("solid_1_3", 32'(vif.dout), 32'h123456);
            if (c == 128 + 35) chk("grad_3_2", 32'(vif.dout), 32'h030201);
            if (c == 128 + 19) chk("grad_3_1", 32'(vif.dout), 32'h030102);
        end

        // Grid.
        pattern = 2'd1;
        do_reset();
        for (int c = 0; c < 64; c++) begin
            tick();
            if (c == 16) chk("grid_0_1", 32'(vif.dout), 32'hFFFFFF);
            if (c == 17) chk("grid_1_1", 32'(vif.dout), 32'h000000);
            if (c == 23) chk("grid_7_1", 32'(vif.dout), 32'hFFFFFF);
            if (c == 51) chk("grid_3_3", 32'(vif.dout), 32'hFFFFFF);
        end

        // Reset pulse at line 2 pixel 5, new pattern latched on release.
        pattern = 2'd0;
        do_reset();
        repeat (37) tick();
        reset = 1'b1; pattern = 2'd3; color = 24'hABCDEF;
        tick();
        chk("rp_dout", 32'(vif.dout), 32'h0);
        chk("rp_de", 32'(vif.de_out), 32'h0);
        chk("rp_x", 32'(vif.x), 32'h0);
        chk("rp_y", 32'(vif.y), 32'h0);
        reset = 1'b0;
        tick();
        chk("rel_fs", 32'(vif.frame_start), 32'h1);
        chk("rel_de", 32'(vif.de_out), 32'h1);
        chk("rel_x", 32'(vif.x), 32'h0);
        chk("rel_y", 32'(vif.y), 32'h0);
        chk("rel_dout", 32'(vif.dout), 32'hABCDEF);
        tick();
        chk("rel_dout1", 32'(vif.dout), 32'hABCDEF);

        // Random ce, pattern, colour and occasional reset against the model.
        for (int c = 0; c < 3000; c++) begin
            ce_pix = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) pattern = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) color = 24'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Programmable video timing generator and test-pattern source that drives the scanline/effects chain (`din`, `hs_in`, `vs_in`, `de_in`) of the MiSTer video path. It produces raster timing from parameterised horizontal/vertical geometry, advanced by a pixel clock-enable. It also produces an RGB888 pixel stream for bring-up and calibration, with the pattern selected per frame.

## Interface
- `H_ACTIVE`, 640, active pixels per line.
- `H_FP`, 16, horizontal front porch (pixels).
- `H_SYNC`, 96, horizontal sync width (pixels).
- `H_BP`, 48, horizontal back porch (pixels).
- `V_ACTIVE`, 480, active lines per frame.
- `V_FP`, 10, vertical front porch (lines).
- `V_SYNC`, 2, vertical sync width (lines).
- `V_BP`, 33, vertical back porch (lines).
- `BAR_W`, 80, colour-bar width in pixels; must satisfy 8·BAR_W ≥ H_ACTIVE.
- `clk` in 1: video clock, single clock domain.
- `reset` in 1: synchronous, active-high.
- `ce_pix` in 1: pixel clock enable; all state advances only on `clk` edges with `ce_pix`=1.
- `pattern` in 2: 0 colour bars, 1 grid, 2 gradient, 3 solid.
- `color` in 24: RGB888 for solid pattern.
- `dout` out 24: RGB888 pixel, {r,g,b}.
- `hs_out` out 1: horizontal sync, active-high.
- `vs_out` out 1: vertical sync, active-high.
- `de_out` out 1: data enable, high in active area.
- `x` out 12: active-area column of current `dout`.
- `y` out 12: active-area row of current `dout`.
- `frame_start` out 1: high for the one pixel at (0,0).

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Both must be ≤ 4096.
- Counters `hcnt` (0..H_TOTAL-1) and `vcnt` (0..V_TOTAL-1):
  - `hcnt` increments on each ce cycle.
  - At H_TOTAL-1, `hcnt` wraps to 0 and `vcnt` increments.
  - At V_TOTAL-1 with `hcnt` wrapping, `vcnt` wraps to 0.
- Horizontal regions:
  - active: `hcnt` < H_ACTIVE.
  - front porch.
  - sync: H_ACTIVE+H_FP ≤ `hcnt` < H_ACTIVE+H_FP+H_SYNC.
  - back porch.
- Vertical regions are the same scheme on `vcnt`. `vs` changes together with `hcnt`=0, so `vs` edges coincide with line starts.
- `de` = h_active AND v_active.
- Outside `de`: `dout`=0, `x`/`y` hold their last active values.
- Pattern latch:
  - `pattern` and `color` are sampled into `pat_q`/`col_q` only on the ce cycle where `hcnt`=0 and `vcnt`=0.
  - Changes mid-frame take effect next frame; no tearing.
- Bars:
  - Bar index increments every BAR_W active pixels (bar counter, no divider) and resets at line start.
  - Colours by index 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Index saturates at 7.
- Grid: FFFFFF when x[3:0]=0, y[3:0]=0, x=H_ACTIVE-1 or y=V_ACTIVE-1; else 000000.
- Gradient: {x[7:0], y[7:0], x[7:0]^y[7:0]}.
- Solid: `col_q`.

## Timing
- All outputs are registered and update only on ce cycles. Each update reflects the pre-increment counter state of that edge: one ce-cycle latency, with `hs`/`vs`/`de`/`dout` mutually aligned.
- Between ce cycles, all outputs hold.
- Reset:
  - Counters go to 0.
  - `pat_q` goes to 0 and `col_q` to 000000.
  - All outputs go to 0.
  - `reset` overrides `ce_pix`.
- After reset:
  - The first ce edge with `reset` low loads `pat_q` from `pattern`.
  - It outputs pixel (0,0): `de_out`=1, `frame_start`=1, `x`=0, `y`=0.
- Reset asserted mid-frame: outputs are 0 on the next `clk` edge, and the raster restarts at (0,0) as above.
- Consumer sync edges:
  - `hs_out` falls after H_SYNC ce-cycles high, once per line.
  - `vs_out` is high for exactly V_SYNC·H_TOTAL ce-cycles per frame.
- `ce_pix` permanently high is legal: one pixel per clock.

## Test plan
Small geometry for all scenarios: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), BAR_W=1, `ce_pix`=1.
- Reset release, `pattern`=0 → first line `dout` = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Then `de_out`=0 and `dout`=0 for 8 pixels; `hs_out`=1 on pixels 10..12 of each line; `frame_start`=1 only at pixel 0 of line 0.
- Full frame count → `de_out` high 32 cycles per 128-cycle frame; `vs_out` high 32 consecutive cycles starting at line 5 pixel 0; pattern repeats every 128 cycles.
- `pattern`=3, `color`=123456, switched to `pattern`=2 at line 2 → solid 123456 until frame end. Next frame is gradient; pixel (3,2) = 030201.
- `ce_pix` toggling 1/0 → every output holds on ce=0 cycles; sequence is identical to the first scenario, stretched ×2.
- `reset` pulsed at line 2 pixel 5 → outputs 0 next edge. After release, first pixel is (0,0) with `frame_start`=1; pattern is re-latched.
- `pattern`=1 → (0,1)=FFFFFF, (1,1)=000000, (7,1)=FFFFFF, (3,3)=FFFFFF.
